// File: rtl/seq_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes for a small datapath.
// Define SEQ_CONTROL_STACK_EN to enable push, pop and stack-form load; otherwise those opcodes are illegal.
module seq_control #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  input  logic              mem_ack,
  input  logic              flag_neg,
  input  logic              flag_zero,
  output logic              fetch_req,
  output logic              pc_inc,
  output logic              jump_take,
  output logic              alu_en,
  output logic              cmp_en,
  output logic              reg_we,
  output logic              const_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic              stack_op,
  output logic [1:0]        alu_func,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [REG_AW-1:0] reg_x,
  output logic [REG_AW-1:0] reg_y,
  output logic [DATA_W-1:0] const_val,
  output logic              halted,
  output logic              illegal
);

  localparam int IMM_W = DATA_W - 4 - REG_AW;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};
`ifdef SEQ_CONTROL_STACK_EN
  localparam logic STACK_EN = 1'b1;
`else
  localparam logic STACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] ir_r;
  logic [3:0]        op_s;
  logic              fa_s, fb_s;
  logic [REG_AW-1:0] r0_s, r1_s, r2_s;
  logic [IMM_W-1:0]  imm_s;
  logic [DATA_W-1:0] imm_sx_s;
  logic              is_stack_s, legal_s, is_alu_s, is_mem_s, mem_wr_s, is_jump_s, take_s;

  logic [1:0]        func_s;
  logic [REG_AW-1:0] waddr_s, x_s, y_s;
  logic [DATA_W-1:0] cval_s;
  logic              csel_s;
  logic fetch_req_s, pc_inc_s, jump_take_s, alu_en_s, cmp_en_s, reg_we_s;
  logic mem_req_s, mem_we_s, stack_op_s, halted_s, illegal_s;

  assign op_s     = ir_r[DATA_W-1:DATA_W-4];
  assign fa_s     = ir_r[DATA_W-5];
  assign fb_s     = ir_r[DATA_W-6];
  assign r0_s     = ir_r[REG_AW-1:0];
  assign r1_s     = ir_r[2*REG_AW-1:REG_AW];
  assign r2_s     = ir_r[3*REG_AW-1:2*REG_AW];
  assign imm_s    = ir_r[DATA_W-5:REG_AW];
  assign imm_sx_s = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};

  // Load form selects stack via bit DATA_W-5; bit DATA_W-6 low turns it into a write.
  assign is_stack_s = ((op_s == 4'h9) && fa_s) || (op_s == 4'hB) || (op_s == 4'hC);
  assign legal_s    = !is_stack_s || STACK_EN;
  assign is_alu_s   = (op_s >= 4'h1) && (op_s <= 4'h6);
  assign is_mem_s   = (op_s >= 4'h9) && (op_s <= 4'hC);
  assign mem_wr_s   = ((op_s == 4'h9) && !fb_s) || (op_s == 4'hA) || (op_s == 4'hB);
  assign is_jump_s  = (op_s >= 4'hD);
  assign take_s     = ((op_s == 4'hD) && flag_neg) || ((op_s == 4'hE) && flag_zero) || (op_s == 4'hF);

  // Operand field decode of the instruction register; captured when DECODE completes.
  always_comb begin
    func_s  = 2'b00;
    waddr_s = {REG_AW{1'b0}};
    x_s     = {REG_AW{1'b0}};
    y_s     = {REG_AW{1'b0}};
    cval_s  = {DATA_W{1'b0}};
    csel_s  = 1'b0;
    case (op_s)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7: begin
        waddr_s = r2_s;
        x_s     = r1_s;
        y_s     = r0_s;
        case (op_s)
          4'h1:       func_s = 2'b10;
          4'h2:       func_s = 2'b11;
          4'h4, 4'h6: func_s = 2'b01;
          default:    func_s = 2'b00;
        endcase
      end
      4'h5: begin
        waddr_s = r0_s;
        x_s     = r0_s;
        csel_s  = 1'b1;
        // Negative immediates become a subtract of the magnitude.
        if (imm_s[IMM_W-1]) begin
          func_s = 2'b01;
          cval_s = ~imm_sx_s + ONE;
        end else begin
          func_s = 2'b00;
          cval_s = imm_sx_s;
        end
      end
      4'h8: begin
        waddr_s = r0_s;
        x_s     = r0_s;
        csel_s  = 1'b1;
        cval_s  = imm_sx_s;
      end
      4'h9, 4'hA, 4'hB, 4'hC: begin
        waddr_s = r1_s;
        y_s     = r1_s;
        x_s     = r0_s;
      end
      4'hD, 4'hE, 4'hF: begin
        if (fa_s) begin
          csel_s = 1'b1;
          cval_s = {{(DATA_W-ADDR_W){1'b0}}, ir_r[ADDR_W-1:0]};
        end else begin
          x_s = r0_s;
        end
      end
      default: begin
        func_s = 2'b00;
      end
    endcase
  end

  // Next-state and next-strobe logic; strobes are registered so they coincide with the state entered.
  always_comb begin
    state_s     = state_r;
    fetch_req_s = 1'b0;
    pc_inc_s    = 1'b0;
    jump_take_s = 1'b0;
    alu_en_s    = 1'b0;
    cmp_en_s    = 1'b0;
    reg_we_s    = 1'b0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    stack_op_s  = 1'b0;
    halted_s    = 1'b0;
    illegal_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_FETCH;
          fetch_req_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (instr_valid) begin
          state_s = ST_DECODE;
        end else begin
          fetch_req_s = 1'b1;
        end
      end
      ST_DECODE: begin
        if (op_s == 4'h0) begin
          state_s  = ST_HALT;
          halted_s = 1'b1;
        end else if (!legal_s) begin
          state_s     = ST_FETCH;
          illegal_s   = 1'b1;
          pc_inc_s    = 1'b1;
          fetch_req_s = 1'b1;
        end else begin
          state_s  = ST_EXEC;
          alu_en_s = is_alu_s;
          cmp_en_s = (op_s == 4'h6);
        end
      end
      ST_EXEC: begin
        if (is_mem_s) begin
          state_s    = ST_MEM;
          mem_req_s  = 1'b1;
          mem_we_s   = mem_wr_s;
          stack_op_s = is_stack_s && STACK_EN;
        end else if (is_jump_s) begin
          state_s     = ST_FETCH;
          fetch_req_s = 1'b1;
          jump_take_s = take_s;
          pc_inc_s    = !take_s;
        end else if (op_s == 4'h6) begin
          state_s     = ST_FETCH;
          fetch_req_s = 1'b1;
          pc_inc_s    = 1'b1;
        end else begin
          state_s  = ST_WB;
          reg_we_s = 1'b1;
          pc_inc_s = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (mem_we) begin
            state_s     = ST_FETCH;
            fetch_req_s = 1'b1;
            pc_inc_s    = 1'b1;
          end else begin
            state_s  = ST_WB;
            reg_we_s = 1'b1;
            pc_inc_s = 1'b1;
          end
        end else begin
          mem_req_s  = 1'b1;
          mem_we_s   = mem_we;
          stack_op_s = stack_op;
        end
      end
      ST_WB: begin
        state_s     = ST_FETCH;
        fetch_req_s = 1'b1;
      end
      ST_HALT: begin
        if (start) begin
          state_s     = ST_FETCH;
          fetch_req_s = 1'b1;
          pc_inc_s    = 1'b1;
        end else begin
          halted_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, instruction register and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ir_r      <= {DATA_W{1'b0}};
      fetch_req <= 1'b0;
      pc_inc    <= 1'b0;
      jump_take <= 1'b0;
      alu_en    <= 1'b0;
      cmp_en    <= 1'b0;
      reg_we    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      stack_op  <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      const_sel <= 1'b0;
      alu_func  <= 2'b00;
      reg_waddr <= {REG_AW{1'b0}};
      reg_x     <= {REG_AW{1'b0}};
      reg_y     <= {REG_AW{1'b0}};
      const_val <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      fetch_req <= fetch_req_s;
      pc_inc    <= pc_inc_s;
      jump_take <= jump_take_s;
      alu_en    <= alu_en_s;
      cmp_en    <= cmp_en_s;
      reg_we    <= reg_we_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      stack_op  <= stack_op_s;
      halted    <= halted_s;
      illegal   <= illegal_s;
      if ((state_r == ST_FETCH) && instr_valid) begin
        ir_r <= instr;
      end
      // Operand selects stay stable from EXEC until the next instruction decodes.
      if (state_r == ST_DECODE) begin
        const_sel <= csel_s;
        alu_func  <= func_s;
        reg_waddr <= waddr_s;
        reg_x     <= x_s;
        reg_y     <= y_s;
        const_val <= cval_s;
      end
    end
  end

endmodule

// File: tb/tb_seq_control.sv
// Scoreboard bench for seq_control (default build, stack opcodes disabled).
module tb_seq_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        mem_ack;
  logic        flag_neg = 1'b0;
  logic        flag_zero = 1'b0;
  logic        fetch_req, pc_inc, jump_take, alu_en, cmp_en, reg_we, const_sel;
  logic        mem_req, mem_we, stack_op, halted, illegal;
  logic [1:0]  alu_func;
  logic [3:0]  reg_waddr, reg_x, reg_y;
  logic [15:0] const_val;

  seq_control #(.DATA_W(16), .REG_AW(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .instr_valid(instr_valid),
    .mem_ack(mem_ack), .flag_neg(flag_neg), .flag_zero(flag_zero),
    .fetch_req(fetch_req), .pc_inc(pc_inc), .jump_take(jump_take), .alu_en(alu_en),
    .cmp_en(cmp_en), .reg_we(reg_we), .const_sel(const_sel), .mem_req(mem_req),
    .mem_we(mem_we), .stack_op(stack_op), .alu_func(alu_func), .reg_waddr(reg_waddr),
    .reg_x(reg_x), .reg_y(reg_y), .const_val(const_val), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] P_PC  = 11'h400;
  localparam logic [10:0] P_JT  = 11'h200;
  localparam logic [10:0] P_ALU = 11'h100;
  localparam logic [10:0] P_CMP = 11'h080;
  localparam logic [10:0] P_WE  = 11'h040;
  localparam logic [10:0] P_CS  = 11'h020;
  localparam logic [10:0] P_MR  = 11'h010;
  localparam logic [10:0] P_MW  = 11'h008;
  localparam logic [10:0] P_HLT = 11'h002;
  localparam logic [10:0] P_ILL = 11'h001;

  logic [40:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          we_cyc = 0;
  int          ack_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input string nm, input logic [10:0] fl, input logic [1:0] f,
                           input logic [3:0] w, input logic [3:0] x, input logic [3:0] y,
                           input logic [15:0] c);
    exp_q.push_back({fl, f, w, x, y, c});
    name_q.push_back(nm);
  endtask

  task automatic do_instr(input logic [15:0] w, output int fc);
    int k;
    k = 0;
    fc = -1;
    do begin
      @(negedge clk);
      k++;
    end while (!fetch_req && k < 50);
    if (!fetch_req) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_timeout: got fetch_req=0, expected 1 within 50 cycles");
    end else begin
      fc = cyc;
      instr = w;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
    end
  endtask

  // Monitor: every output event pops one expected record.
  initial begin : monitor
    logic [40:0] o;
    logic        hprev;
    string       nm;
    hprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        o = {pc_inc, jump_take, alu_en, cmp_en, reg_we, const_sel, mem_req, mem_we, stack_op,
             halted, illegal, alu_func, reg_waddr, reg_x, reg_y, const_val};
        if (pc_inc || jump_take || alu_en || cmp_en || reg_we || mem_req || illegal ||
            (halted && !hprev)) begin
          if (reg_we) we_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got %h, expected no event", o);
          end else begin
            nm = name_q.pop_front();
            check(nm, {23'd0, o}, {23'd0, exp_q.pop_front()});
          end
        end
        hprev = halted;
      end else begin
        hprev = 1'b0;
      end
    end
  end

  // Memory responder: acknowledges after ack_delay cycles of mem_req.
  initial begin : acker
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        cnt++;
        mem_ack = (cnt > ack_delay);
      end else begin
        cnt = 0;
        mem_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int fc;
    int k;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {22'd0, fetch_req, pc_inc, jump_take, alu_en, cmp_en, reg_we, const_sel, mem_req, mem_we,
           stack_op, halted, illegal, alu_func, reg_waddr, reg_x, reg_y, const_val}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_fetch", {63'd0, fetch_req}, 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    expect_ev("add_exec", P_ALU, 2'b00, 4'd1, 4'd2, 4'd3, 16'h0000);
    expect_ev("add_wb", P_WE | P_PC, 2'b00, 4'd1, 4'd2, 4'd3, 16'h0000);
    do_instr(16'h3123, fc);
    repeat (3) @(negedge clk);
    check("add_latency", 64'(we_cyc - fc), 64'd3);

    expect_ev("addi_exec", P_ALU | P_CS, 2'b01, 4'd1, 4'd1, 4'd0, 16'h0080);
    expect_ev("addi_wb", P_WE | P_PC | P_CS, 2'b01, 4'd1, 4'd1, 4'd0, 16'h0080);
    do_instr(16'h5801, fc);

    expect_ev("cpyc_wb", P_WE | P_PC | P_CS, 2'b00, 4'd2, 4'd2, 4'd0, 16'hFFFF);
    do_instr(16'h8FF2, fc);

    ack_delay = 3;
    for (int i = 0; i < 4; i++) expect_ev("load_mem", P_MR, 2'b00, 4'd1, 4'd2, 4'd1, 16'h0000);
    expect_ev("load_wb", P_WE | P_PC, 2'b00, 4'd1, 4'd2, 4'd1, 16'h0000);
    do_instr(16'h9412, fc);

    expect_ev("comp_exec", P_ALU | P_CMP, 2'b01, 4'd0, 4'd4, 4'd5, 16'h0000);
    expect_ev("comp_next", P_PC, 2'b01, 4'd0, 4'd4, 4'd5, 16'h0000);
    do_instr(16'h6045, fc);

    flag_zero = 1'b1;
    expect_ev("jmpe_taken", P_JT | P_CS, 2'b00, 4'd0, 4'd0, 4'd0, 16'h0005);
    do_instr(16'hE805, fc);
    repeat (2) @(negedge clk);
    flag_zero = 1'b0;
    expect_ev("jmpe_not_taken", P_PC | P_CS, 2'b00, 4'd0, 4'd0, 4'd0, 16'h0005);
    do_instr(16'hE805, fc);

    expect_ev("jump_reg", P_JT, 2'b00, 4'd0, 4'd3, 4'd0, 16'h0000);
    do_instr(16'hF003, fc);

    ack_delay = 0;
    expect_ev("stor_mem", P_MR | P_MW, 2'b00, 4'd2, 4'd3, 4'd2, 16'h0000);
    expect_ev("stor_next", P_PC, 2'b00, 4'd2, 4'd3, 4'd2, 16'h0000);
    do_instr(16'hA123, fc);

    expect_ev("push_illegal", P_PC | P_ILL, 2'b00, 4'd0, 4'd3, 4'd0, 16'h0000);
    do_instr(16'hB003, fc);

    expect_ev("halt_enter", P_HLT, 2'b00, 4'd0, 4'd0, 4'd0, 16'h0000);
    do_instr(16'h0000, fc);
    repeat (4) @(negedge clk);
    expect_ev("halt_exit", P_PC, 2'b00, 4'd0, 4'd0, 4'd0, 16'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("halt_exit_fetch", {63'd0, fetch_req}, 64'd1);

    ack_delay = 20;
    expect_ev("load_before_reset", P_MR, 2'b00, 4'd1, 4'd2, 4'd1, 16'h0000);
    do_instr(16'h9412, fc);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_req && k < 20);
    check("mem_req_reached", {63'd0, mem_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {22'd0, fetch_req, pc_inc, jump_take, alu_en, cmp_en, reg_we, const_sel, mem_req, mem_we,
              stack_op, halted, illegal, alu_func, reg_waddr, reg_x, reg_y, const_val}, 64'd0);
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter DATA_W, default 16: instruction and constant width; minimum 16.
REQ-002 Parameter REG_AW, default 4: register-address width.
REQ-003 Parameter ADDR_W, default 10: program-address width; SHALL satisfy ADDR_W <= DATA_W-6.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  leave IDLE or HALT.
REQ-008 instr, instr_valid  input  DATA_W, 1  fetched word; fetch acknowledge.
REQ-009 mem_ack  input  1  data-memory acknowledge.
REQ-010 flag_neg, flag_zero  input  1 each  registered ALU status.
REQ-011 fetch_req, pc_inc, jump_take  output  1 each  fetch request; PC-increment pulse; jump pulse.
REQ-012 alu_en, cmp_en, reg_we, const_sel, mem_req, mem_we, stack_op  output  1 each  datapath strobes.
REQ-013 alu_func  output  2  00 add, 01 sub, 10 and, 11 or.
REQ-014 reg_waddr, reg_x, reg_y  output  REG_AW each  register selects.
REQ-015 const_val  output  DATA_W  immediate or jump target.
REQ-016 halted, illegal  output  1 each  halt status; one-cycle illegal-opcode pulse.

Function
REQ-017 Opcode SHALL be instr[DATA_W-1:DATA_W-4]; encodings 0 halt, 1 and, 2 or, 3 add, 4 sub, 5 addi, 6 comp, 7 copy, 8 cpyc, 9 load, A stor, B push, C pop, D jmpl, E jmpe, F jump.
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; every output is registered.
REQ-019 IDLE: wait for start, then go to FETCH; HALT: on start pulse pc_inc and go to FETCH.
REQ-020 FETCH: hold fetch_req high until instr_valid, latch instr into the instruction register, go to DECODE.
REQ-021 DECODE (1 cycle): opcode 0 goes to HALT with no pc_inc; an opcode disabled by configuration pulses illegal and pc_inc and goes to FETCH; all other opcodes go to EXEC.
REQ-022 EXEC (1 cycle): ALU ops assert alu_en, and comp asserts alu_en and cmp_en; opcodes 9-C go to MEM; opcodes 1-5, 7, 8 go to WB; 6 and D-F pulse pc_inc or jump_take and go to FETCH.
REQ-023 MEM: hold mem_req, mem_we and addresses stable until mem_ack; reads then go to WB, writes pulse pc_inc and go to FETCH.
REQ-024 WB (1 cycle): pulse reg_we and pc_inc, then go to FETCH.
REQ-025 Latency with zero-wait fetch: ALU op 4 cycles, memory op 5 cycles plus mem_ack wait, jump 3 cycles.
REQ-026 Immediate field SHALL be IMM_W = DATA_W-4-REG_AW bits above the destination field. cpyc sign-extends it into const_val. addi with a negative immediate sets alu_func=01 and const_val to its magnitude; the most negative value yields 2^(IMM_W-1).
REQ-027 Jumps: instr[DATA_W-5]=1 selects const_sel=1 with const_val = zero-extended instr[ADDR_W-1:0]; otherwise reg_x supplies the target. D takes on flag_neg, E on flag_zero, F always; flags are sampled in EXEC; not-taken pulses pc_inc.
REQ-028 Load (9): instr[DATA_W-5] selects stack_op, and instr[DATA_W-6]=0 converts it to a write; stor (A) writes; push (B) writes with stack_op; pop (C) reads with stack_op.
REQ-029 instr_valid outside FETCH, mem_ack outside MEM, and start outside IDLE/HALT SHALL be ignored.
REQ-030 In each state, strobes not named for that state SHALL be 0.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and all outputs to 0, including mid-handshake (mem_req and fetch_req drop asynchronously).
REQ-032 The instruction register SHALL reset to 0; the first cycle after rst_n rises is IDLE.

Configuration
REQ-033 With macro SEQ_CONTROL_STACK_EN defined, opcodes B, C and stack-form 9 execute per REQ-028.
REQ-034 Without SEQ_CONTROL_STACK_EN, stack_op is tied 0 and those opcodes are illegal per REQ-021.

Verification
REQ-035 Reset, start, instr=0x3123 with zero-wait -> alu_en in EXEC, reg_we with reg_waddr=1, x=2, y=3 in WB, 4 cycles.
REQ-036 addi with imm=0x80 (DATA_W=16) -> alu_func=01, const_val=0x0080; cpyc imm=0xFF -> const_val=0xFFFF.
REQ-037 load 0x9412 with mem_ack delayed 3 cycles -> mem_req high 4 cycles and stable, then WB reg_we with reg_waddr=1.
REQ-038 jmpe 0xE805 with flag_zero=1 -> jump_take, const_val=0x005; with flag_zero=0 -> pc_inc only.
REQ-039 halt 0x0000 -> halted=1 with no pc_inc; start -> pc_inc, then FETCH.
REQ-040 rst_n low while mem_req is high -> mem_req=0 with no clock edge; build without SEQ_CONTROL_STACK_EN and issue push 0xB003 -> illegal pulse, no mem_req.
